// File: rtl/fx3_sfifo_pkg.sv
// -----------------------------------------------------------------------------
// fx3_sfifo_pkg
// Shared constants for the FX3 synchronous Slave FIFO responder.
//   ADDR_*    : thread addresses seen on the 2-bit ADDR bus
//   ST_*      : OUT-buffer FSM encodings (LOAD = host filling, SERVE = master reading)
//   RD_LAT    : edges between the read strobe sample and data on DQ
//   is_in_addr: true for the two FPGA->host (IN) threads
// -----------------------------------------------------------------------------
package fx3_sfifo_pkg;

  localparam logic [1:0] ADDR_OUT = 2'b11;
  localparam logic [1:0] ADDR_IN0 = 2'b00;
  localparam logic [1:0] ADDR_IN1 = 2'b01;

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam int RD_LAT = 2;

  function automatic logic is_in_addr(input logic [1:0] a);
    return (a == ADDR_IN0) || (a == ADDR_IN1);
  endfunction

endpackage

// File: rtl/fx3_sfifo_buf.sv
// -----------------------------------------------------------------------------
// fx3_sfifo_buf
// Single-clock FIFO with occupancy output. Push is dropped when full, pop is
// ignored when empty, push+pop in one cycle keeps occupancy. Read data is the
// word at the head (show-ahead), so it is valid whenever o_empty is low.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (pointers/occupancy only)
//   i_push/i_din write request and word
//   i_pop        consume head word
//   o_dout       head word
//   o_occ        occupancy, 0..DEPTH
//   o_empty/o_full
// -----------------------------------------------------------------------------
module fx3_sfifo_buf #(
  parameter int W     = 33,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_occ,
  output logic          o_empty,
  output logic          o_full
);

  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_occ;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_occ == '0);
  assign o_full  = (r_occ == DEPTH_OCC);
  assign o_occ   = r_occ;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (AW+1)'(1);
        2'b01:   r_occ <= r_occ - (AW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/fx3_sfifo_responder.sv
// -----------------------------------------------------------------------------
// fx3_sfifo_responder
// FX3 side of the 32-bit synchronous Slave FIFO link. Decodes the master's
// strobes, serves reads from the OUT buffer (host->FPGA, thread 3) with the
// two-cycle FX3 latency, accepts writes into the IN buffer (FPGA->host,
// threads 0/1), and drives FLAGA..FLAGD as registered status.
// Ports:
//   clk_pll, reset                     link clock, async active-high reset
//   slcs_n/slrd_n/sloe_n/slwr_n        master strobes (low active)
//   pktend_n, addr, dq_in              packet end, thread address, write data
//   dq_out, dq_oe                      read data and its drive enable
//   flag_a..flag_d                     IN not full / IN free>WR_WM /
//                                      OUT not empty / OUT occ>RD_WM
//   h_ld_*                             host side loading the OUT buffer
//   h_dr_*                             host side draining the IN buffer
//   err_underrun, err_overrun          sticky error indicators
// -----------------------------------------------------------------------------
module fx3_sfifo_responder
  import fx3_sfifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int RD_WM  = 4,
  parameter int WR_WM  = 4
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic              slcs_n,
  input  logic              slrd_n,
  input  logic              sloe_n,
  input  logic              slwr_n,
  input  logic              pktend_n,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] dq_in,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              flag_a,
  output logic              flag_b,
  output logic              flag_c,
  output logic              flag_d,
  input  logic              h_ld_valid,
  input  logic [DATA_W-1:0] h_ld_data,
  input  logic              h_ld_last,
  output logic              h_ld_ready,
  output logic              h_dr_valid,
  output logic [DATA_W-1:0] h_dr_data,
  output logic              h_dr_thread,
  input  logic              h_dr_ready,
  output logic              err_underrun,
  output logic              err_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] RD_WM_OCC = (AW+1)'(RD_WM);
  localparam logic [AW:0] WR_WM_OCC = (AW+1)'(WR_WM);

  // Strobe decode. A write strobe masks any read strobe on the same edge.
  logic w_cs;
  logic w_wr;
  logic w_rd;
  assign w_cs = !slcs_n;
  assign w_wr = w_cs && !slwr_n && is_in_addr(addr);
  assign w_rd = w_cs && !slrd_n && slwr_n && (addr == ADDR_OUT);

  // The IN buffer streams words to the host without packet framing, so a
  // packet-end commit (zero-length or not) has nothing further to flush.
  logic w_unused_pktend;
  assign w_unused_pktend = pktend_n;

  logic [0:0]        r_state;
  logic              r_live;
  logic              w_out_empty;
  logic              w_out_full;
  logic [AW:0]       w_out_occ;
  logic [DATA_W-1:0] w_out_dout;
  logic              w_out_pop;
  logic              w_ld_accept;
  logic              w_in_empty;
  logic              w_in_full;
  logic [AW:0]       w_in_occ;
  logic [DATA_W:0]   w_in_dout;
  logic              w_dr_pop;

  // r_live holds the load handshake low until the first edge after reset.
  assign h_ld_ready  = r_live && (r_state == ST_LOAD) && !w_out_full;
  assign w_ld_accept = h_ld_valid && h_ld_ready;
  assign w_out_pop   = w_rd && !w_out_empty;

  assign h_dr_valid  = !w_in_empty;
  assign h_dr_data   = w_in_dout[DATA_W-1:0];
  assign h_dr_thread = w_in_dout[DATA_W];
  assign w_dr_pop    = h_dr_valid && h_dr_ready;

  fx3_sfifo_buf #(.W(DATA_W), .DEPTH(DEPTH)) u_out_buf (
    .clk     (clk_pll),
    .rst     (reset),
    .i_push  (w_ld_accept),
    .i_din   (h_ld_data),
    .i_pop   (w_out_pop),
    .o_dout  (w_out_dout),
    .o_occ   (w_out_occ),
    .o_empty (w_out_empty),
    .o_full  (w_out_full)
  );

  fx3_sfifo_buf #(.W(DATA_W+1), .DEPTH(DEPTH)) u_in_buf (
    .clk     (clk_pll),
    .rst     (reset),
    .i_push  (w_wr),
    .i_din   ({addr[0], dq_in}),
    .i_pop   (w_dr_pop),
    .o_dout  (w_in_dout),
    .o_occ   (w_in_occ),
    .o_empty (w_in_empty),
    .o_full  (w_in_full)
  );

  // OUT FSM: host fills a packet in LOAD, master drains it in SERVE.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOAD;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_LOAD:  if (w_ld_accept && h_ld_last) r_state <= ST_SERVE;
        default:  if (w_out_empty) r_state <= ST_LOAD;
      endcase
    end
  end

  // Status flags and sticky errors, registered from current buffer state.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      flag_a       <= 1'b0;
      flag_b       <= 1'b0;
      flag_c       <= 1'b0;
      flag_d       <= 1'b0;
      err_underrun <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      flag_a <= (w_in_occ != DEPTH_OCC);
      flag_b <= ((DEPTH_OCC - w_in_occ) > WR_WM_OCC);
      flag_c <= (r_state == ST_SERVE) && !w_out_empty;
      flag_d <= (r_state == ST_SERVE) && (w_out_occ > RD_WM_OCC);
      if (w_rd && w_out_empty) err_underrun <= 1'b1;
      if (w_wr && w_in_full)   err_overrun  <= 1'b1;
    end
  end

  // Read pipeline control. An empty-buffer read still occupies a slot so a
  // zero word is delivered at the normal latency.
  logic              r_vld_p0;
  logic              r_vld_p1;
  logic              r_oe_p0;
  logic [DATA_W-1:0] r_rd_data_p0;
  logic [DATA_W-1:0] r_rd_data_p1;

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_oe_p0  <= 1'b0;
      dq_oe    <= 1'b0;
      dq_out   <= '0;
    end else begin
      r_vld_p0 <= w_rd;
      r_vld_p1 <= r_vld_p0;
      r_oe_p0  <= w_cs && !sloe_n;
      dq_oe    <= r_oe_p0;
      if (r_vld_p1) dq_out <= r_rd_data_p1;
    end
  end

  // ---- stage p0: capture head word on the strobe edge
  always_ff @(posedge clk_pll) begin
    if (w_rd) r_rd_data_p0 <= w_out_empty ? '0 : w_out_dout;
  end

  // ---- stage p1: second latency cycle before DQ
  always_ff @(posedge clk_pll) begin
    if (r_vld_p0) r_rd_data_p1 <= r_rd_data_p0;
  end

endmodule

// File: tb/tb_fx3_sfifo_responder.sv
// -----------------------------------------------------------------------------
// tb_fx3_sfifo_responder
// Directed + randomized bench for fx3_sfifo_responder. A queue-based model of
// the link (OUT/IN word queues, a delivery schedule for read data, sticky
// errors, LOAD/SERVE mode) predicts every output one edge at a time.
// -----------------------------------------------------------------------------
module tb_fx3_sfifo_responder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
  localparam int RD_WM  = 4;
  localparam int WR_WM  = 4;

  logic              clk_pll = 1'b0;
  logic              reset   = 1'b1;
  logic              slcs_n, slrd_n, sloe_n, slwr_n, pktend_n;
  logic [1:0]        addr;
  logic [DATA_W-1:0] dq_in;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe, flag_a, flag_b, flag_c, flag_d;
  logic              h_ld_valid, h_ld_last, h_ld_ready;
  logic [DATA_W-1:0] h_ld_data;
  logic              h_dr_valid, h_dr_thread, h_dr_ready;
  logic [DATA_W-1:0] h_dr_data;
  logic              err_underrun, err_overrun;

  always #5 clk_pll = ~clk_pll;

  fx3_sfifo_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_WM(RD_WM), .WR_WM(WR_WM)) dut (
    .clk_pll(clk_pll), .reset(reset), .slcs_n(slcs_n), .slrd_n(slrd_n), .sloe_n(sloe_n),
    .slwr_n(slwr_n), .pktend_n(pktend_n), .addr(addr), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .flag_a(flag_a), .flag_b(flag_b), .flag_c(flag_c), .flag_d(flag_d),
    .h_ld_valid(h_ld_valid), .h_ld_data(h_ld_data), .h_ld_last(h_ld_last),
    .h_ld_ready(h_ld_ready), .h_dr_valid(h_dr_valid), .h_dr_data(h_dr_data),
    .h_dr_thread(h_dr_thread), .h_dr_ready(h_dr_ready),
    .err_underrun(err_underrun), .err_overrun(err_overrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  typedef struct { int due; logic [DATA_W-1:0] d; } deliv_t;
  logic [DATA_W-1:0] out_q[$];
  logic [DATA_W:0]   in_q[$];
  deliv_t            sched_q[$];
  int                cyc = 0;
  bit                m_serve, m_live, m_oe_seen;
  bit                e_oe, e_uf, e_of, e_fa, e_fb, e_fc, e_fd;
  logic [DATA_W-1:0] e_dq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    out_q.delete(); in_q.delete(); sched_q.delete();
    m_serve = 0; m_live = 0; m_oe_seen = 0;
    e_oe = 0; e_uf = 0; e_of = 0; e_fa = 0; e_fb = 0; e_fc = 0; e_fd = 0;
    e_dq = '0;
  endtask

  task automatic compare_all();
    check("flag_a", flag_a, e_fa);
    check("flag_b", flag_b, e_fb);
    check("flag_c", flag_c, e_fc);
    check("flag_d", flag_d, e_fd);
    check("dq_oe", dq_oe, e_oe);
    check("dq_out", dq_out, e_dq);
    check("err_underrun", err_underrun, e_uf);
    check("err_overrun", err_overrun, e_of);
    check("h_ld_ready", h_ld_ready, m_live && !m_serve && (out_q.size() < DEPTH));
    check("h_dr_valid", h_dr_valid, in_q.size() > 0);
    if (in_q.size() > 0) begin
      check("h_dr_data", h_dr_data, in_q[0][DATA_W-1:0]);
      check("h_dr_thread", h_dr_thread, in_q[0][DATA_W]);
    end
  endtask

  // One clock edge: model the edge from the inputs as driven, then compare.
  task automatic step();
    int  out_n = out_q.size();
    int  in_n  = in_q.size();
    bit  cs    = !slcs_n;
    bit  wr    = cs && !slwr_n && (addr == 2'b00 || addr == 2'b01);
    bit  rd    = cs && !slrd_n && slwr_n && (addr == 2'b11);
    bit  ld    = m_live && !m_serve && (out_n < DEPTH) && h_ld_valid;
    bit  dr    = (in_n > 0) && h_dr_ready;
    bit  serve_pre = m_serve;
    deliv_t dv;
    @(posedge clk_pll);
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      e_fa = in_n < DEPTH;
      e_fb = (DEPTH - in_n) > WR_WM;
      e_fc = serve_pre && (out_n > 0);
      e_fd = serve_pre && (out_n > RD_WM);
      e_oe = m_oe_seen;
      m_oe_seen = cs && !sloe_n;
      if (sched_q.size() > 0 && sched_q[0].due == cyc) begin
        e_dq = sched_q[0].d;
        void'(sched_q.pop_front());
      end
      if (rd) begin
        dv.due = cyc + 2;
        if (out_n > 0) dv.d = out_q.pop_front();
        else begin dv.d = '0; e_uf = 1; end
        sched_q.push_back(dv);
      end
      if (dr) void'(in_q.pop_front());
      if (wr) begin
        if (in_n < DEPTH) in_q.push_back({addr[0], dq_in});
        else e_of = 1;
      end
      if (ld) out_q.push_back(h_ld_data);
      if (!serve_pre) begin
        if (ld && h_ld_last) m_serve = 1;
      end else if (out_n == 0) begin
        m_serve = 0;
      end
      m_live = 1;
    end
    #1;
    compare_all();
  endtask

  task automatic drive_idle();
    slcs_n = 1'b1; slrd_n = 1'b1; sloe_n = 1'b1; slwr_n = 1'b1; pktend_n = 1'b1;
    addr = 2'b00; dq_in = '0; h_ld_valid = 1'b0; h_ld_data = '0; h_ld_last = 1'b0;
    h_dr_ready = 1'b0;
  endtask

  task automatic load_packet(input int len);
    for (int i = 0; i < len; i++) begin
      h_ld_valid = 1'b1;
      h_ld_data  = $urandom;
      h_ld_last  = (i == len - 1);
      step();
    end
    h_ld_valid = 1'b0;
    h_ld_last  = 1'b0;
  endtask

  logic [DATA_W-1:0] words [5];
  int guard;

  initial begin
    drive_idle();
    model_clear();

    // Reset state
    repeat (2) step();
    check("rst_dq_oe", dq_oe, 1'b0);
    check("rst_flag_a", flag_a, 1'b0);
    check("rst_flag_c", flag_c, 1'b0);
    check("rst_ld_ready", h_ld_ready, 1'b0);
    check("rst_dq_out", dq_out, 32'h0);
    reset = 1'b0;
    step();
    check("live_flag_a", flag_a, 1'b1);
    check("live_flag_b", flag_b, 1'b1);
    check("live_ld_ready", h_ld_ready, 1'b1);

    // 1: five-word packet
    words[0] = 32'hCAFEB0BA; words[1] = 32'h3; words[2] = 32'h08070605;
    words[3] = $urandom;     words[4] = $urandom;
    for (int i = 0; i < 5; i++) begin
      h_ld_valid = 1'b1; h_ld_data = words[i]; h_ld_last = (i == 4);
      step();
    end
    h_ld_valid = 1'b0; h_ld_last = 1'b0;
    check("t1_flag_c_lag", flag_c, 1'b0);
    step();
    check("t1_flag_c", flag_c, 1'b1);
    check("t1_flag_d", flag_d, 1'b1);
    check("t1_ld_ready", h_ld_ready, 1'b0);

    // 2: five-read burst
    slcs_n = 1'b0; sloe_n = 1'b0; addr = 2'b11; slrd_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) check("t2_flag_d_fall", flag_d, 1'b0);
      if (i >= 2) check("t2_dq_word", dq_out, words[i-2]);
    end
    slrd_n = 1'b1;
    step();
    check("t2_dq_word3", dq_out, words[3]);
    check("t2_flag_c_fall", flag_c, 1'b0);
    check("t2_back_to_load", h_ld_ready, 1'b1);
    step();
    check("t2_dq_word4", dq_out, words[4]);
    check("t2_dq_oe", dq_oe, 1'b1);

    // 3: read of empty buffer
    slrd_n = 1'b0;
    step();
    slrd_n = 1'b1;
    check("t3_underrun", err_underrun, 1'b1);
    repeat (2) step();
    check("t3_dq_zero", dq_out, 32'h0);
    drive_idle();
    step();
    h_ld_valid = 1'b1; h_ld_data = 32'h5A5A1234; h_ld_last = 1'b1;
    step();
    h_ld_valid = 1'b0; h_ld_last = 1'b0;
    step();
    slcs_n = 1'b0; addr = 2'b11; slrd_n = 1'b0;
    step();
    slrd_n = 1'b1;
    repeat (2) step();
    check("t3_one_word_pkt", dq_out, 32'h5A5A1234);
    drive_idle();
    repeat (2) step();

    // Random packets with random read gaps, chip-select drops and OE
    for (int p = 0; p < 6; p++) begin
      load_packet(int'($urandom_range(1, 10)));
      step();
      guard = 0;
      while ((m_serve || sched_q.size() > 0) && guard < 300) begin
        slcs_n = ($urandom_range(0, 7) == 0);
        slrd_n = !((out_q.size() > 0) && ($urandom_range(0, 3) != 0));
        sloe_n = 1'($urandom_range(0, 1));
        addr   = 2'b11;
        step();
        guard++;
      end
      check("pkt_drain_bound", guard < 300, 1'b1);
      drive_idle();
      step();
    end

    // 4: fill IN buffer to overflow, then drain
    slcs_n = 1'b0; addr = 2'b00; h_dr_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      slwr_n = 1'b0; dq_in = i;
      step();
      if (i == DEPTH - 5) check("t4_flag_b_hi", flag_b, 1'b1);
      if (i == DEPTH - 4) check("t4_flag_b_lo", flag_b, 1'b0);
      if (i == DEPTH - 1) check("t4_flag_a_hi", flag_a, 1'b1);
      if (i == DEPTH - 1) check("t4_no_overrun", err_overrun, 1'b0);
      if (i == DEPTH)     check("t4_flag_a_lo", flag_a, 1'b0);
      if (i == DEPTH)     check("t4_overrun", err_overrun, 1'b1);
    end
    slwr_n = 1'b1;
    h_dr_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      if (j % 512 == 0) check("t4_drain_data", h_dr_data, j);
      if (j % 512 == 0) check("t4_drain_thread", h_dr_thread, 1'b0);
      step();
    end
    check("t4_drained", h_dr_valid, 1'b0);
    drive_idle();
    step();

    // 6: reset during a read burst
    load_packet(8);
    step();
    slcs_n = 1'b0; sloe_n = 1'b0; addr = 2'b11; slrd_n = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    model_clear();
    check("t6_dq_oe", dq_oe, 1'b0);
    check("t6_flag_c", flag_c, 1'b0);
    check("t6_flag_a", flag_a, 1'b0);
    check("t6_dq_out", dq_out, 32'h0);
    check("t6_underrun", err_underrun, 1'b0);
    drive_idle();
    step();
    reset = 1'b0;
    repeat (3) step();
    check("t6_out_empty", flag_c, 1'b0);
    check("t6_dq_discard", dq_out, 32'h0);
    check("t6_ld_ready", h_ld_ready, 1'b1);

    // Zero-length commit and simultaneous read/write strobes
    slcs_n = 1'b0; pktend_n = 1'b0; addr = 2'b00;
    step();
    pktend_n = 1'b1;
    step();
    check("zlp_no_push", h_dr_valid, 1'b0);
    addr = 2'b11; slrd_n = 1'b0; slwr_n = 1'b0;
    step();
    slrd_n = 1'b1; slwr_n = 1'b1;
    step();
    check("wr_wins_no_read", err_underrun, 1'b0);

    // 5: alternating threads with host draining continuously
    h_dr_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      slwr_n = 1'b0;
      addr   = 2'($urandom_range(0, 1));
      dq_in  = $urandom;
      step();
    end
    slwr_n = 1'b1;
    step();
    check("t5_no_overrun", err_overrun, 1'b0);
    check("t5_empty", h_dr_valid, 1'b0);
    drive_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
